// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Serves 32-bit CPU loads/stores from 8-word lines; misses refill from block memory.
module dcache_ctrl #(
  parameter int SETS = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         memread,
  input  logic         memwrite,
  input  logic [31:0]  addr,
  input  logic [31:0]  writedata,
  output logic [31:0]  readdata,
  output logic         stall,
  output logic         blockread,
  output logic         blockwrite,
  output logic [31:0]  blockaddr,
  output logic [255:0] writeblock,
  input  logic [255:0] readblock,
  input  logic         ready
);

  localparam int IDXW = $clog2(SETS);
  localparam int TAGW = 27 - IDXW;

  typedef enum logic [2:0] {
    IDLE,
    WB_REQ,
    WB_WAIT,
    FILL_REQ,
    FILL_WAIT
  } state_t;

  state_t state;

  logic [SETS-1:0] valid;
  logic [SETS-1:0] dirty;
  logic [TAGW-1:0] tags  [SETS];
  logic [255:0]    lines [SETS];

  // Block address of the miss being serviced, held so a dropped request still completes.
  logic [26:0]     miss_blk;

  logic [IDXW-1:0] idx;
  logic [TAGW-1:0] tag;
  logic [2:0]      wsel;
  logic [IDXW-1:0] midx;
  logic [TAGW-1:0] mtag;
  logic            req;
  logic            hit;
  logic [31:0]     rword;
  logic            unused_addr_bits;

  assign idx  = addr[5 +: IDXW];
  assign tag  = addr[31 -: TAGW];
  assign wsel = addr[4:2];
  assign midx = miss_blk[IDXW-1:0];
  assign mtag = miss_blk[26 -: TAGW];
  assign req  = memread | memwrite;
  assign hit  = valid[idx] && (tags[idx] == tag);

  assign unused_addr_bits = ^addr[1:0];

  always_comb begin
    rword = '0;
    for (int k = 0; k < 8; k++) begin
      if (wsel == 3'(k)) rword = lines[idx][(7-k)*32 +: 32];
    end
  end

  assign readdata   = hit ? rword : 32'd0;
  assign stall      = (state != IDLE) || (req && !hit);
  assign writeblock = lines[midx];

  // Control: FSM, valid/dirty bits and registered memory strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      valid      <= '0;
      dirty      <= '0;
      blockread  <= 1'b0;
      blockwrite <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req && hit && memwrite) begin
            dirty[idx] <= 1'b1;
          end else if (req && !hit && ready) begin
            blockread <= 1'b1;
            if (valid[idx] && dirty[idx]) begin
              state      <= WB_REQ;
              blockwrite <= 1'b1;
            end else begin
              state      <= FILL_REQ;
              blockwrite <= 1'b0;
            end
          end
        end
        WB_REQ: begin
          if (!ready) begin
            state      <= WB_WAIT;
            blockread  <= 1'b0;
            blockwrite <= 1'b0;
          end
        end
        WB_WAIT: begin
          if (ready) begin
            state       <= FILL_REQ;
            dirty[midx] <= 1'b0;
            blockread   <= 1'b1;
            blockwrite  <= 1'b0;
          end
        end
        FILL_REQ: begin
          if (!ready) begin
            state     <= FILL_WAIT;
            blockread <= 1'b0;
          end
        end
        FILL_WAIT: begin
          if (ready) begin
            state       <= IDLE;
            valid[midx] <= 1'b1;
            dirty[midx] <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          blockread  <= 1'b0;
          blockwrite <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: miss address, block address, tag and line storage (never reset).
  always_ff @(posedge clk) begin
    if (state == IDLE && req && !hit && ready) begin
      miss_blk <= addr[31:5];
      if (valid[idx] && dirty[idx]) begin
        blockaddr <= {5'b0, tags[idx], idx};
      end else begin
        blockaddr <= {5'b0, addr[31:5]};
      end
    end else if (state == WB_WAIT && ready) begin
      blockaddr <= {5'b0, miss_blk};
    end

    if (state == FILL_WAIT && ready) begin
      lines[midx] <= readblock;
      tags[midx]  <= mtag;
    end else if (state == IDLE && req && hit && memwrite) begin
      for (int k = 0; k < 8; k++) begin
        if (wsel == 3'(k)) lines[idx][(7-k)*32 +: 32] <= writedata;
      end
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a 5-cycle block memory model.
module tb_dcache_ctrl;

  localparam int SETS = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         memread;
  logic         memwrite;
  logic [31:0]  addr;
  logic [31:0]  writedata;
  logic [31:0]  readdata;
  logic         stall;
  logic         blockread;
  logic         blockwrite;
  logic [31:0]  blockaddr;
  logic [255:0] writeblock;
  logic [255:0] readblock;
  logic         ready;

  int checks = 0;
  int errors = 0;

  logic [31:0]  mem [4096];
  int           busy;
  logic         op_wr;
  int           op_blk;
  logic [255:0] op_data;
  int           nfill;
  int           nwb;
  int           last_fill_blk;
  int           last_wb_blk;
  logic [255:0] last_wb_data;
  logic         req_while_busy;

  dcache_ctrl #(.SETS(SETS)) dut (
    .clk        (clk),
    .reset      (reset),
    .memread    (memread),
    .memwrite   (memwrite),
    .addr       (addr),
    .writedata  (writedata),
    .readdata   (readdata),
    .stall      (stall),
    .blockread  (blockread),
    .blockwrite (blockwrite),
    .blockaddr  (blockaddr),
    .writeblock (writeblock),
    .readblock  (readblock),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  // Block memory: takes a request on negedge while idle, completes 5 negedges later.
  always @(negedge clk) begin
    if (busy > 0) begin
      if (blockread) req_while_busy = 1'b1;
      busy = busy - 1;
      if (busy == 0) begin
        for (int k = 0; k < 8; k++) begin
          if (op_wr) mem[op_blk*8 + k] = op_data[(7-k)*32 +: 32];
          else       readblock[(7-k)*32 +: 32] = mem[op_blk*8 + k];
        end
        ready = 1'b1;
      end
    end else if (ready && blockread) begin
      op_wr   = blockwrite;
      op_blk  = int'(blockaddr[8:0]);
      op_data = writeblock;
      if (blockwrite) begin
        nwb          = nwb + 1;
        last_wb_blk  = op_blk;
        last_wb_data = writeblock;
      end else begin
        nfill         = nfill + 1;
        last_fill_blk = op_blk;
      end
      ready = 1'b0;
      busy  = 5;
    end
  end

  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, output int cyc, output logic [31:0] data);
    memread   = rd;
    memwrite  = wr;
    addr      = a;
    writedata = d;
    cyc       = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (stall && cyc < 300);
    data = readdata;
    @(posedge clk);
    #1;
    memread  = 1'b0;
    memwrite = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    memread   = 1'b0;
    memwrite  = 1'b0;
    addr      = 32'h0;
    writedata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    checks++;
    if (blockread !== 1'b0) begin errors++; $display("FAIL reset_blockread: got %b expected 0", blockread); end
    checks++;
    if (blockwrite !== 1'b0) begin errors++; $display("FAIL reset_blockwrite: got %b expected 0", blockwrite); end
    checks++;
    if (readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h expected 0", readdata); end
  endtask

  task automatic test_load_miss_fill();
    int cyc;
    logic [31:0] d;
    do_access(1'b1, 1'b0, 32'h24, 32'h0, cyc, d);
    checks++;
    if (!(cyc > 1 && cyc < 300)) begin errors++; $display("FAIL t1_miss_stalls: got %0d cycles expected >1", cyc); end
    checks++;
    if (nfill !== 1 || nwb !== 0) begin errors++; $display("FAIL t1_traffic: got fills=%0d wbs=%0d expected 1/0", nfill, nwb); end
    checks++;
    if (last_fill_blk !== 1) begin errors++; $display("FAIL t1_fill_addr: got %0d expected 1", last_fill_blk); end
    checks++;
    if (d !== 32'hC0DE0009) begin errors++; $display("FAIL t1_readdata: got %h expected c0de0009", d); end
    do_access(1'b1, 1'b0, 32'h24, 32'h0, cyc, d);
    checks++;
    if (cyc !== 1) begin errors++; $display("FAIL t1_hit_cycles: got %0d expected 1", cyc); end
    checks++;
    if (d !== 32'hC0DE0009 || nfill !== 1) begin
      errors++; $display("FAIL t1_hit_data: got %h fills=%0d expected c0de0009 fills=1", d, nfill);
    end
  endtask

  task automatic test_store_hit();
    int cyc;
    logic [31:0] d;
    do_access(1'b0, 1'b1, 32'h24, 32'hDEADBEEF, cyc, d);
    checks++;
    if (cyc !== 1) begin errors++; $display("FAIL t2_store_cycles: got %0d expected 1", cyc); end
    checks++;
    if (nfill !== 1 || nwb !== 0) begin errors++; $display("FAIL t2_traffic: got fills=%0d wbs=%0d expected 1/0", nfill, nwb); end
    do_access(1'b1, 1'b0, 32'h24, 32'h0, cyc, d);
    checks++;
    if (cyc !== 1 || d !== 32'hDEADBEEF) begin
      errors++; $display("FAIL t2_reload: got %h in %0d cycles expected deadbeef in 1", d, cyc);
    end
  endtask

  task automatic test_alias_evict();
    int cyc;
    logic [31:0] d;
    do_access(1'b1, 1'b0, 32'h24 + 32*SETS, 32'h0, cyc, d);
    checks++;
    if (nwb !== 1 || last_wb_blk !== 1) begin errors++; $display("FAIL t3_writeback: got wbs=%0d blk=%0d expected 1/1", nwb, last_wb_blk); end
    checks++;
    if (last_wb_data[223:192] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL t3_wb_word1: got %h expected deadbeef", last_wb_data[223:192]);
    end
    checks++;
    if (nfill !== 2 || last_fill_blk !== 9) begin errors++; $display("FAIL t3_fill: got fills=%0d blk=%0d expected 2/9", nfill, last_fill_blk); end
    checks++;
    if (d !== 32'hC0DE0049) begin errors++; $display("FAIL t3_alias_data: got %h expected c0de0049", d); end
    do_access(1'b1, 1'b0, 32'h24, 32'h0, cyc, d);
    checks++;
    if (!(cyc > 1) || d !== 32'hDEADBEEF) begin
      errors++; $display("FAIL t3_refetch: got %h in %0d cycles expected deadbeef after miss", d, cyc);
    end
    checks++;
    if (nwb !== 1 || nfill !== 3) begin errors++; $display("FAIL t3_refetch_traffic: got wbs=%0d fills=%0d expected 1/3", nwb, nfill); end
  endtask

  task automatic test_store_miss();
    int cyc;
    logic [31:0] d;
    do_access(1'b0, 1'b1, 32'h40, 32'h12345678, cyc, d);
    checks++;
    if (nwb !== 1 || nfill !== 4 || last_fill_blk !== 2) begin
      errors++; $display("FAIL t4_fill_only: got wbs=%0d fills=%0d blk=%0d expected 1/4/2", nwb, nfill, last_fill_blk);
    end
    do_access(1'b1, 1'b0, 32'h40, 32'h0, cyc, d);
    checks++;
    if (cyc !== 1 || d !== 32'h12345678) begin
      errors++; $display("FAIL t4_merged: got %h in %0d cycles expected 12345678 in 1", d, cyc);
    end
    do_access(1'b1, 1'b0, 32'h40 + 32*SETS, 32'h0, cyc, d);
    checks++;
    if (nwb !== 2 || last_wb_blk !== 2 || last_wb_data[255:224] !== 32'h12345678) begin
      errors++; $display("FAIL t4_dirty_wb: got wbs=%0d blk=%0d w0=%h expected 2/2/12345678", nwb, last_wb_blk, last_wb_data[255:224]);
    end
    checks++;
    if (d !== 32'hC0DE0050) begin errors++; $display("FAIL t4_alias_data: got %h expected c0de0050", d); end
  endtask

  task automatic test_reset_midfill();
    int cyc;
    int w;
    logic [31:0] d;
    memread = 1'b1;
    addr    = 32'h300;
    w       = 0;
    do begin @(posedge clk); #1; w++; end while (ready && w < 50);
    reset   = 1'b1;
    memread = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (blockread !== 1'b0 || blockwrite !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL t5_after_reset: got br=%b bw=%b stall=%b expected 0/0/0", blockread, blockwrite, stall);
    end
    memread = 1'b1;
    addr    = 32'h24;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL t5_valid_cleared: got stall=%b expected 1", stall); end
    do_access(1'b1, 1'b0, 32'h24, 32'h0, cyc, d);
    checks++;
    if (req_while_busy !== 1'b0) begin errors++; $display("FAIL t5_wait_ready: got early request=%b expected 0", req_while_busy); end
    checks++;
    if (d !== 32'hDEADBEEF || last_fill_blk !== 1) begin
      errors++; $display("FAIL t5_refill: got %h blk=%0d expected deadbeef/1", d, last_fill_blk);
    end
  endtask

  task automatic test_drop_request();
    int cyc;
    int w;
    int fills0;
    logic [31:0] d;
    fills0  = nfill;
    memread = 1'b1;
    addr    = 32'h3A4;
    w       = 0;
    do begin @(posedge clk); #1; w++; end while (ready && w < 50);
    memread = 1'b0;
    do begin @(posedge clk); #1; w++; end while (!ready && w < 100);
    checks++;
    if (stall !== 1'b0 || blockread !== 1'b0 || w >= 100) begin
      errors++; $display("FAIL t6_idle_after_drop: got stall=%b br=%b waited=%0d expected 0/0/<100", stall, blockread, w);
    end
    do_access(1'b1, 1'b0, 32'h3A4, 32'h0, cyc, d);
    checks++;
    if (cyc !== 1 || d !== 32'hC0DE00E9) begin
      errors++; $display("FAIL t6_hit_after_drop: got %h in %0d cycles expected c0de00e9 in 1", d, cyc);
    end
    checks++;
    if (nfill !== fills0 + 1) begin errors++; $display("FAIL t6_fill_count: got %0d expected %0d", nfill, fills0 + 1); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'hC0DE0000 + 32'(i);
    ready          = 1'b1;
    busy           = 0;
    readblock      = '0;
    nfill          = 0;
    nwb            = 0;
    last_fill_blk  = -1;
    last_wb_blk    = -1;
    last_wb_data   = '0;
    req_while_busy = 1'b0;
    test_reset();
    test_load_miss_fill();
    test_store_hit();
    test_alias_evict();
    test_store_miss();
    test_reset_midfill();
    test_drop_request();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
